accel_pair_scheduler: RTL

- Sequences the pipelined acceleration datapath for one N-body step: issues every (i,j) body-pair address into the position/mass RAM read ports, one pair per cycle.
- Carries a matching tag through a fixed-latency delay line, so the velocity accumulate/write-back stage receives the pair indices and framing flags exactly when results emerge.
- Sits between the top-level go/done handshake logic and the RAMs plus getAccl. Replaces the ad-hoc timer/counter sequencing in the top-level state machine.

---
 rtl/accel_pair_scheduler_if.sv | 34 +++
 rtl/accel_pair_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/accel_pair_scheduler_if.sv
// Pair-issue and write-back tag bundle between the go/done control, the RAM read ports and the accumulator.
// master = pass controller side, slave = scheduler side.
interface accel_pair_scheduler_if #(
   parameter int BODY_ADDR_WIDTH = 9
);
   logic                       start;
   logic                       abort;
   logic [BODY_ADDR_WIDTH:0]   n_bodies;
   logic                       issue_valid;
   logic [BODY_ADDR_WIDTH-1:0] issue_i;
   logic [BODY_ADDR_WIDTH-1:0] issue_j;
   logic                       wb_valid;
   logic [BODY_ADDR_WIDTH-1:0] wb_i;
   logic [BODY_ADDR_WIDTH-1:0] wb_j;
   logic                       wb_self;
   logic                       wb_first;
   logic                       wb_last;
   logic                       busy;
   logic                       done;

   modport master (
      output start, abort, n_bodies,
      input  issue_valid, issue_i, issue_j,
      input  wb_valid, wb_i, wb_j, wb_self, wb_first, wb_last,
      input  busy, done
   );

   modport slave (
      input  start, abort, n_bodies,
      output issue_valid, issue_i, issue_j,
      output wb_valid, wb_i, wb_j, wb_self, wb_first, wb_last,
      output busy, done
   );
endinterface

// File: rtl/accel_pair_scheduler.sv
// Issues all N*N (i,j) body pairs row-major, one per cycle, and replays each pair's tag PIPE_LATENCY cycles later.
// Issue is registered one cycle after start; no backpressure, the datapath must accept one pair every cycle.
module accel_pair_scheduler #(
   parameter int BODIES          = 512,
   parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
   parameter int PIPE_LATENCY    = 123
) (
   input logic                   clk,
   input logic                   rst_n,
   accel_pair_scheduler_if.slave bus
);
   localparam int NW = BODY_ADDR_WIDTH + 1;
   localparam logic [NW-1:0] BODIES_N = NW'(BODIES);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic                       vld;
      logic [BODY_ADDR_WIDTH-1:0] i;
      logic [BODY_ADDR_WIDTH-1:0] j;
      logic                       is_self;
      logic                       is_first;
      logic                       is_last;
   } tag_t;

   state_t                     state_q, state_d;
   logic [NW-1:0]              n_q, n_d;
   logic [BODY_ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d;
   logic                       issue_vld_q, issue_vld_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       flush;
   logic [NW-1:0]              n_clamped;
   logic [NW-1:0]              nm1;
   logic                       wb_final;
   tag_t                       tag_in_d;
   tag_t                       line_q [PIPE_LATENCY];

   assign nm1       = n_q - 1'b1;
   assign n_clamped = (bus.n_bodies > BODIES_N) ? BODIES_N : bus.n_bodies;
   assign wb_final  = line_q[PIPE_LATENCY-1].vld && line_q[PIPE_LATENCY-1].is_last &&
                      ({1'b0, line_q[PIPE_LATENCY-1].i} == nm1);

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      i_d         = i_q;
      j_d         = j_q;
      issue_vld_d = issue_vld_q;
      done_d      = 1'b0;
      flush       = 1'b0;
      if (bus.abort) begin
         state_d     = IDLE;
         issue_vld_d = 1'b0;
         i_d         = '0;
         j_d         = '0;
         flush       = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  n_d = n_clamped;
                  if (n_clamped == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d     = ISSUE;
                     issue_vld_d = 1'b1;
                     i_d         = '0;
                     j_d         = '0;
                  end
               end
            end
            ISSUE: begin
               // Wrap is decided by comparison with N-1, never by counter overflow.
               if ({1'b0, j_q} == nm1) begin
                  j_d = '0;
                  if ({1'b0, i_q} == nm1) begin
                     state_d     = DRAIN;
                     issue_vld_d = 1'b0;
                     i_d         = '0;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
            DRAIN: begin
               if (wb_final) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // Flags are zeroed on idle slots so wb_* stay quiet whenever wb_valid is low.
   always_comb begin
      tag_in_d = '0;
      if (issue_vld_q) begin
         tag_in_d.vld      = 1'b1;
         tag_in_d.i        = i_q;
         tag_in_d.j        = j_q;
         tag_in_d.is_self  = (i_q == j_q);
         tag_in_d.is_first = (j_q == '0);
         tag_in_d.is_last  = ({1'b0, j_q} == nm1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         n_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         issue_vld_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         i_q         <= i_d;
         j_q         <= j_d;
         issue_vld_q <= issue_vld_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_LATENCY; k++) line_q[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < PIPE_LATENCY; k++) line_q[k] <= '0;
      end else begin
         line_q[0] <= tag_in_d;
         for (int k = 1; k < PIPE_LATENCY; k++) line_q[k] <= line_q[k-1];
      end
   end

   assign bus.issue_valid = issue_vld_q;
   assign bus.issue_i     = i_q;
   assign bus.issue_j     = j_q;
   assign bus.wb_valid    = line_q[PIPE_LATENCY-1].vld;
   assign bus.wb_i        = line_q[PIPE_LATENCY-1].i;
   assign bus.wb_j        = line_q[PIPE_LATENCY-1].j;
   assign bus.wb_self     = line_q[PIPE_LATENCY-1].is_self;
   assign bus.wb_first    = line_q[PIPE_LATENCY-1].is_first;
   assign bus.wb_last     = line_q[PIPE_LATENCY-1].is_last;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule
